// File: rtl/mac_rr_arbiter_if.sv
// mac_rr_arbiter_if
//   Bundle between MAC clients and the shared-multiplier arbiter.
//   Clients sit on the master modport, the arbiter on the slave modport.
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_a/req_b         : packed signed operands, slice i = requester i
//   req_clr             : per-requester "load instead of accumulate"
//   rsp_valid/rsp_id    : single-cycle result pulse and owning requester
//   rsp_prod/rsp_acc    : signed product and updated accumulator
//   busy                : any pipeline stage occupied
interface mac_rr_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int ACC_W = 2*WIDTH+4,
  parameter int IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_clr;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [2*WIDTH-1:0]    rsp_prod;
  logic [ACC_W-1:0]      rsp_acc;
  logic                  busy;

  modport master (
    output req_valid, req_a, req_b, req_clr,
    input  req_ready, rsp_valid, rsp_id, rsp_prod, rsp_acc, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_clr,
    output req_ready, rsp_valid, rsp_id, rsp_prod, rsp_acc, busy
  );
endinterface

// File: rtl/mac_rr_arbiter.sv
// mac_rr_arbiter
//   Round-robin arbiter feeding one shared signed WIDTH x WIDTH multiplier.
//   Each requester owns a private ACC_W-bit accumulator. Accepted requests
//   pass issue -> multiply -> accumulate, one result per request, in order.
//   Ports:
//     clk  : rising-edge clock
//     rst  : synchronous active-high reset
//     bus  : mac_rr_arbiter_if.slave (request handshake, operands, results, busy)
module mac_rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int ACC_W = 2*WIDTH+4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  mac_rr_arbiter_if.slave bus
);

  logic [IDW-1:0]  rr_ptr;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gnt_id;
  logic            accept;

  // S1 issue
  logic               s1_valid;
  logic [WIDTH-1:0]   s1_a;
  logic [WIDTH-1:0]   s1_b;
  logic               s1_clr;
  logic [IDW-1:0]     s1_id;

  // S2 multiply
  logic               s2_valid;
  logic signed [2*WIDTH-1:0] s2_prod;
  logic               s2_clr;
  logic [IDW-1:0]     s2_id;

  // S3 accumulate / response
  logic               rsp_valid_q;
  logic [IDW-1:0]     rsp_id_q;
  logic [2*WIDTH-1:0] rsp_prod_q;
  logic [ACC_W-1:0]   rsp_acc_q;
  logic [ACC_W-1:0]   acc [NREQ];

  logic [2*WIDTH-1:0] mul_full;
  logic [ACC_W-1:0]   p_ext;
  logic [ACC_W-1:0]   acc_next;

  // Cyclic first-valid search starting at rr_ptr.
  always_comb begin
    logic [IDW-1:0] idx;
    logic           found;
    grant  = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!found && bus.req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gnt_id     = idx;
      end
    end
    if (rst) begin
      grant = '0;
    end
  end

  assign accept = |grant;

  // Sign-extending both operands to 2*WIDTH makes the low 2*WIDTH bits of
  // an unsigned multiply equal the exact signed product, including (-2^(W-1))^2.
  assign mul_full = {{WIDTH{s1_a[WIDTH-1]}}, s1_a} * {{WIDTH{s1_b[WIDTH-1]}}, s1_b};

  always_comb begin
    p_ext    = ACC_W'(s2_prod);
    acc_next = s2_clr ? p_ext : acc[s2_id] + p_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      s1_valid    <= 1'b0;
      s1_a        <= '0;
      s1_b        <= '0;
      s1_clr      <= 1'b0;
      s1_id       <= '0;
      s2_valid    <= 1'b0;
      s2_prod     <= '0;
      s2_clr      <= 1'b0;
      s2_id       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_prod_q  <= '0;
      rsp_acc_q   <= '0;
      for (int i = 0; i < NREQ; i++) begin
        acc[i] <= '0;
      end
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a   <= bus.req_a[gnt_id*WIDTH +: WIDTH];
        s1_b   <= bus.req_b[gnt_id*WIDTH +: WIDTH];
        s1_clr <= bus.req_clr[gnt_id];
        s1_id  <= gnt_id;
        rr_ptr <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
      end

      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_prod <= mul_full;
        s2_clr  <= s1_clr;
        s2_id   <= s1_id;
      end

      // Response fields hold their last value while rsp_valid is low.
      rsp_valid_q <= s2_valid;
      if (s2_valid) begin
        acc[s2_id] <= acc_next;
        rsp_id_q   <= s2_id;
        rsp_prod_q <= s2_prod;
        rsp_acc_q  <= acc_next;
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_prod  = rsp_prod_q;
  assign bus.rsp_acc   = rsp_acc_q;
  assign bus.busy      = s1_valid | s2_valid | rsp_valid_q;

endmodule

// File: tb/tb_mac_rr_arbiter.sv
module tb_mac_rr_arbiter;
  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int ACC_W = 2*WIDTH+4;
  localparam int IDW   = $clog2(NREQ);

  logic clk;
  logic rst;

  mac_rr_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .ACC_W(ACC_W), .IDW(IDW)) bus ();

  mac_rr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .ACC_W(ACC_W), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int                 due;
    logic [IDW-1:0]     id;
    logic [2*WIDTH-1:0] prod;
    logic [ACC_W-1:0]   acc;
  } exp_t;

  typedef struct {
    bit                 chk_id;
    bit                 chk_pa;
    logic [IDW-1:0]     id;
    logic [2*WIDTH-1:0] prod;
    logic [ACC_W-1:0]   acc;
  } pin_t;

  exp_t q[$];
  pin_t pin_q[$];

  // model state (written only by the posedge process)
  int              cnt = 0;
  int              ptr = 0;
  bit              was_rst = 1'b0;
  logic [NREQ-1:0] acc_mask = '0;
  longint          macc [NREQ];

  // compare state (written only by the negedge process)
  int                 total = 0;
  int                 bad = 0;
  logic [2*WIDTH-1:0] last_prod = '0;
  logic [ACC_W-1:0]   last_acc = '0;
  bit                 end_done = 1'b0;

  bit end_req = 1'b0;

  // stimulus state
  logic [NREQ-1:0]  v_r;
  logic [NREQ-1:0]  clr_r;
  logic [WIDTH-1:0] a_r [NREQ];
  logic [WIDTH-1:0] b_r [NREQ];

  function automatic logic [NREQ-1:0] grant_of(input logic [NREQ-1:0] v, input int p);
    logic [NREQ-1:0] g;
    g = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (g == '0 && v[(p + k) % NREQ]) g[(p + k) % NREQ] = 1'b1;
    end
    return g;
  endfunction

  // Reference model: accumulators are updated in acceptance order, which is
  // also result order, so the accumulated value can be fixed at accept time.
  always @(posedge clk) begin
    logic [NREQ-1:0] g;
    exp_t e;
    cnt++;
    was_rst  = rst;
    acc_mask = '0;
    if (rst) begin
      q.delete();
      for (int i = 0; i < NREQ; i++) macc[i] = 0;
      ptr = 0;
    end else begin
      g = grant_of(bus.req_valid, ptr);
      for (int i = 0; i < NREQ; i++) begin
        if (g[i]) begin
          longint pa, pb, pr;
          pa = longint'($signed(bus.req_a[i*WIDTH +: WIDTH]));
          pb = longint'($signed(bus.req_b[i*WIDTH +: WIDTH]));
          pr = pa * pb;
          macc[i] = bus.req_clr[i] ? pr : macc[i] + pr;
          e.due  = cnt + 2;
          e.id   = IDW'(i);
          e.prod = pr[2*WIDTH-1:0];
          e.acc  = macc[i][ACC_W-1:0];
          q.push_back(e);
          ptr = (i + 1) % NREQ;
          acc_mask = g;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cnt);
    end
  endtask

  always @(negedge clk) begin
    bit   exp_v;
    pin_t pp;
    if (cnt >= 1) begin
      if (was_rst) begin
        last_prod = '0;
        last_acc  = '0;
      end
      while (q.size() > 0 && q[0].due < cnt) q.delete(0);
      exp_v = (q.size() > 0 && q[0].due == cnt);
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_v));
      chk("busy", 64'(bus.busy), 64'(q.size() > 0));
      chk("req_ready", 64'(bus.req_ready), 64'(rst ? '0 : grant_of(bus.req_valid, ptr)));
      if (exp_v) begin
        chk("rsp_id", 64'(bus.rsp_id), 64'(q[0].id));
        chk("rsp_prod", 64'(bus.rsp_prod), 64'(q[0].prod));
        chk("rsp_acc", 64'(bus.rsp_acc), 64'(q[0].acc));
        last_prod = q[0].prod;
        last_acc  = q[0].acc;
        if (pin_q.size() > 0) begin
          pp = pin_q.pop_front();
          if (pp.chk_id) chk("pin_id", 64'(bus.rsp_id), 64'(pp.id));
          if (pp.chk_pa) begin
            chk("pin_prod", 64'(bus.rsp_prod), 64'(pp.prod));
            chk("pin_acc", 64'(bus.rsp_acc), 64'(pp.acc));
          end
        end
      end else begin
        chk("rsp_prod_hold", 64'(bus.rsp_prod), 64'(last_prod));
        chk("rsp_acc_hold", 64'(bus.rsp_acc), 64'(last_acc));
        if (was_rst) chk("rsp_id_rst", 64'(bus.rsp_id), 64'(0));
      end
      if (end_req && !end_done) begin
        chk("pins_left", 64'(pin_q.size()), 64'(0));
        chk("queue_left", 64'(q.size()), 64'(0));
        end_done = 1'b1;
      end
    end
  end

  task automatic drive();
    bus.req_valid = v_r;
    bus.req_clr   = clr_r;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*WIDTH +: WIDTH] = a_r[i];
      bus.req_b[i*WIDTH +: WIDTH] = b_r[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    v_r = '0;
    drive();
    repeat (n) tick();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    v_r = '0;
    drive();
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic add_pin(input bit cid, input bit cpa, input int id,
                         input logic [2*WIDTH-1:0] ep, input logic [ACC_W-1:0] ea);
    pin_t pp;
    pp.chk_id = cid;
    pp.chk_pa = cpa;
    pp.id     = IDW'(id);
    pp.prod   = ep;
    pp.acc    = ea;
    pin_q.push_back(pp);
  endtask

  // Single requester sends one pair; it is the only valid one, so the next
  // edge accepts it.
  task automatic send1(input int id, input int a, input int b, input bit clr, input bit push,
                       input bit cpa, input logic [2*WIDTH-1:0] ep, input logic [ACC_W-1:0] ea);
    v_r        = '0;
    v_r[id]    = 1'b1;
    a_r[id]    = WIDTH'(a);
    b_r[id]    = WIDTH'(b);
    clr_r[id]  = clr;
    drive();
    if (push) add_pin(1'b1, cpa, id, ep, ea);
    tick();
  endtask

  function automatic logic [WIDTH-1:0] rand_op();
    logic [WIDTH-1:0] edge_v [4];
    edge_v[0] = 8'h80;
    edge_v[1] = 8'h7F;
    edge_v[2] = 8'hFF;
    edge_v[3] = 8'h00;
    if ($urandom_range(0, 3) == 0) return edge_v[$urandom_range(0, 3)];
    return WIDTH'($urandom);
  endfunction

  initial begin
    rst   = 1'b1;
    v_r   = '0;
    clr_r = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_r[i] = '0;
      b_r[i] = '0;
    end
    drive();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(10);

    // corner products
    send1(0, -128, -128, 1'b1, 1'b1, 1'b1, 16'h4000, 20'h04000);
    send1(0,   -1,  127, 1'b1, 1'b1, 1'b1, 16'hFF81, 20'hFFF81);
    send1(0,  127,  127, 1'b1, 1'b1, 1'b1, 16'h3F01, 20'h03F01);
    idle(5);

    // back-to-back accumulate on one requester
    send1(2,  3, 4, 1'b1, 1'b1, 1'b1, 16'h000C, 20'h0000C);
    send1(2, -5, 6, 1'b0, 1'b1, 1'b1, 16'hFFE2, 20'hFFFEE);
    send1(2,  2, 2, 1'b0, 1'b1, 1'b1, 16'h0004, 20'hFFFF2);
    idle(5);

    // round robin from index 0
    do_reset(1);
    for (int i = 0; i < NREQ; i++) begin
      a_r[i]   = WIDTH'(i + 1);
      b_r[i]   = WIDTH'(3);
      clr_r[i] = 1'b1;
    end
    v_r = '1;
    drive();
    for (int k = 0; k < 8; k++) add_pin(1'b1, 1'b0, k % NREQ, '0, '0);
    repeat (8) tick();
    idle(5);

    // fairness between requesters 1 and 3, then 1 alone
    v_r = 4'b1010;
    drive();
    add_pin(1'b1, 1'b0, 1, '0, '0);
    add_pin(1'b1, 1'b0, 3, '0, '0);
    add_pin(1'b1, 1'b0, 1, '0, '0);
    add_pin(1'b1, 1'b0, 3, '0, '0);
    repeat (4) tick();
    v_r = 4'b0010;
    drive();
    repeat (3) add_pin(1'b1, 1'b0, 1, '0, '0);
    repeat (3) tick();
    idle(5);

    // accumulator wrap at 2^20
    do_reset(1);
    for (int k = 0; k < 64; k++) begin
      if (k == 62)      send1(0, -128, -128, 1'b0, 1'b1, 1'b1, 16'h4000, 20'hFC000);
      else if (k == 63) send1(0, -128, -128, 1'b0, 1'b1, 1'b1, 16'h4000, 20'h00000);
      else              send1(0, -128, -128, 1'b0, 1'b1, 1'b0, '0, '0);
    end
    idle(5);

    // reset discards an in-flight request and clears the accumulator
    send1(0, 5, 5, 1'b1, 1'b1, 1'b1, 16'h0019, 20'h00019);
    idle(4);
    send1(0, 1, 1, 1'b0, 1'b0, 1'b0, '0, '0);
    do_reset(2);
    send1(0, 2, 3, 1'b0, 1'b1, 1'b1, 16'h0006, 20'h00006);
    idle(5);

    // randomized traffic with occasional resets
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!(v_r[i] && !acc_mask[i])) begin
          v_r[i]   = ($urandom_range(0, 99) < 60);
          a_r[i]   = rand_op();
          b_r[i]   = rand_op();
          clr_r[i] = ($urandom_range(0, 3) == 0);
        end
      end
      drive();
      tick();
    end
    rst = 1'b0;
    idle(8);

    end_req = 1'b1;
    for (int k = 0; k < 10 && !end_done; k++) @(negedge clk);
    if (!end_done) begin
      $display("FAIL end_check: got no final check expected final check");
      $fatal(1, "final check not reached");
    end
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
